// File: rtl/rx_iq_stream_scheduler.sv
// Queues RX1/RX2 IQ sample sets and serves them to the bus engine as a byte stream.
// Define RX_IQ_SEQNUM_EN to prefix every frame with a 16-bit sequence number.
module rx_iq_stream_scheduler #(
  parameter int DEPTH_LOG2 = 3,
  parameter int SAMPLE_W   = 32
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  iq_valid,
  input  logic [SAMPLE_W-1:0]   RX1_I,
  input  logic [SAMPLE_W-1:0]   RX1_Q,
  input  logic [SAMPLE_W-1:0]   RX2_I,
  input  logic [SAMPLE_W-1:0]   RX2_Q,
  input  logic                  rx2_en,
  input  logic                  stream_start,
  input  logic                  stream_stop,
  input  logic                  byte_req,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           overflow_cnt,
  output logic [15:0]           underflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int BPW   = SAMPLE_W / 8;
`ifdef RX_IQ_SEQNUM_EN
  localparam int FRAME_W = 4 * SAMPLE_W + 16;
`else
  localparam int FRAME_W = 4 * SAMPLE_W;
`endif
  localparam int FRAME_BYTES = FRAME_W / 8;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_LONG  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_SHORT = IDX_W'(FRAME_BYTES - 2 * BPW - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [FRAME_W-1:0]    mem_q [DEPTH];
  logic [FRAME_W-1:0]    mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [15:0]           overflow_q, overflow_d, underflow_q, underflow_d;
  logic [1:0]            state_q, state_d;
  logic [FRAME_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frame_rx2_q, frame_rx2_d;
`ifdef RX_IQ_SEQNUM_EN
  logic [15:0]           seq_q, seq_d;
`endif

  logic                  fifo_empty, fifo_full, load_act, pop, push;
  logic [FRAME_W-1:0]    wr_entry, zero_entry;
  logic [IDX_W-1:0]      last_idx;
  logic [7:0]            frame_bytes [FRAME_BYTES];

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(DEPTH));
    load_act   = (state_q == ST_LOAD) && !stream_stop;
    pop        = load_act && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    push       = iq_valid && (!fifo_full || pop);
`ifdef RX_IQ_SEQNUM_EN
    wr_entry   = {seq_q, RX1_Q, RX1_I, RX2_Q, RX2_I};
    zero_entry = {16'hFFFF, {(4 * SAMPLE_W){1'b0}}};
`else
    wr_entry   = {RX1_Q, RX1_I, RX2_Q, RX2_I};
    zero_entry = '0;
`endif
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
`ifdef RX_IQ_SEQNUM_EN
    seq_d      = seq_q;
`endif
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
`ifdef RX_IQ_SEQNUM_EN
      seq_d           = seq_q + 16'd1;
`endif
    end else if (iq_valid && overflow_q != 16'hFFFF) begin
      overflow_d = overflow_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    frame_rx2_d = frame_rx2_q;
    underflow_d = underflow_q;
    last_idx    = frame_rx2_q ? LAST_LONG : LAST_SHORT;
    case (state_q)
      ST_IDLE: begin
        if (stream_start && !stream_stop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (stream_stop) begin
          state_d = ST_IDLE;
        end else begin
          frame_rx2_d = rx2_en;
          hold_d      = pop ? mem_q[rd_ptr_q] : zero_entry;
          idx_d       = '0;
          if (fifo_empty && underflow_q != 16'hFFFF) underflow_d = underflow_q + 16'd1;
          state_d     = stream_start ? ST_LOAD : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stream_stop) begin
          state_d = ST_IDLE;
        end else if (stream_start) begin
          state_d = ST_LOAD;
        end else if (byte_req) begin
          if (idx_q == last_idx) state_d = ST_LOAD;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold register is laid out MSB-first in stream order, so byte k sits k bytes below the top.
  always_comb begin
    for (int i = 0; i < FRAME_BYTES; i++) frame_bytes[i] = hold_q[FRAME_W-1-8*i -: 8];
    byte_valid    = (state_q == ST_SHIFT);
    byte_out      = byte_valid ? frame_bytes[idx_q] : 8'h00;
    fill_level    = count_q;
    overflow_cnt  = overflow_q;
    underflow_cnt = underflow_q;
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= '0;
      underflow_q <= '0;
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      frame_rx2_q <= 1'b0;
`ifdef RX_IQ_SEQNUM_EN
      seq_q       <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      frame_rx2_q <= frame_rx2_d;
`ifdef RX_IQ_SEQNUM_EN
      seq_q       <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_rx_iq_stream_scheduler.sv
// Self-checking bench for rx_iq_stream_scheduler against a queue-based frame model.
// Follows RX_IQ_SEQNUM_EN when defined so the model matches the built design.
module tb_rx_iq_stream_scheduler;

`ifdef RX_IQ_SEQNUM_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        iq_valid;
  logic [31:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic        rx2_en, stream_start, stream_stop, byte_req;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [3:0]  fill_level;
  logic [15:0] overflow_cnt, underflow_cnt;

  int checks   = 0;
  int failures = 0;

  logic [127:0] q_m  [$];
  logic [15:0]  sq_m [$];
  logic [15:0]  seq_m;
  int           ovf_m, unf_m;
  logic [7:0]   exp_b [0:17];
  int           exp_n;

  rx_iq_stream_scheduler dut (
    .clk_in(clk_in), .reset(reset), .iq_valid(iq_valid),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .rx2_en(rx2_en), .stream_start(stream_start), .stream_stop(stream_stop),
    .byte_req(byte_req), .byte_out(byte_out), .byte_valid(byte_valid),
    .fill_level(fill_level), .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    sq_m.delete();
    seq_m = 16'd0;
    ovf_m = 0;
    unf_m = 0;
  endtask

  task automatic model_push(input logic [127:0] set);
    if (q_m.size() < 8) begin
      q_m.push_back(set);
      sq_m.push_back(seq_m);
      seq_m = seq_m + 16'd1;
    end else if (ovf_m < 65535) begin
      ovf_m++;
    end
  endtask

  task automatic drive_set(input logic [127:0] set);
    iq_valid = 1'b1;
    {RX1_Q, RX1_I, RX2_Q, RX2_I} = set;
  endtask

  // One iq_valid strobe carrying the given set.
  task automatic applyStimulus(input logic [127:0] set);
    drive_set(set);
    model_push(set);
    tick();
    iq_valid = 1'b0;
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) applyStimulus({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Expected frame: optional sequence prefix, then RX1_Q, RX1_I[, RX2_Q, RX2_I], each MSB first.
  task automatic model_load(input bit rx2);
    logic [127:0] set;
    logic [15:0]  seq;
    int           words;
    if (q_m.size() != 0) begin
      set = q_m.pop_front();
      seq = sq_m.pop_front();
    end else begin
      set = '0;
      seq = 16'hFFFF;
      if (unf_m < 65535) unf_m++;
    end
    exp_n = 0;
    if (SEQ_ON) begin
      exp_b[0] = seq[15:8];
      exp_b[1] = seq[7:0];
      exp_n    = 2;
    end
    words = rx2 ? 4 : 2;
    for (int w = 0; w < words; w++)
      for (int b = 0; b < 4; b++) begin
        exp_b[exp_n] = set[127 - 32*w - 8*b -: 8];
        exp_n++;
      end
  endtask

  task automatic read_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("byte%0d", k), {24'd0, byte_out}, {24'd0, exp_b[k]});
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checkOutput($sformatf("byte%0d_hold", k), {24'd0, byte_out}, {24'd0, exp_b[k]});
      end
      byte_req = 1'b1;
      tick();
      byte_req = 1'b0;
    end
  endtask

  // Called with the DUT in its load cycle; consumes one whole frame and ends in the next load.
  task automatic consume_frame(input bit rx2);
    model_load(rx2);
    tick();
    checkOutput("underflow_cnt", {16'd0, underflow_cnt}, unf_m);
    checkOutput("valid_after_load", {31'd0, byte_valid}, 32'd1);
    read_bytes(exp_n);
    checkOutput("valid_gap", {31'd0, byte_valid}, 32'd0);
  endtask

  task automatic start_stream();
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
  endtask

  task automatic stop_stream();
    stream_stop = 1'b1;
    tick();
    stream_stop = 1'b0;
    checkOutput("valid_after_stop", {31'd0, byte_valid}, 32'd0);
    checkOutput("byte_after_stop", {24'd0, byte_out}, 32'd0);
  endtask

  task automatic check_levels(input string tag);
    checkOutput({tag, "_fill"}, {28'd0, fill_level}, q_m.size());
    checkOutput({tag, "_ovf"}, {16'd0, overflow_cnt}, ovf_m);
    checkOutput({tag, "_unf"}, {16'd0, underflow_cnt}, unf_m);
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_byte_out", {24'd0, byte_out}, 32'd0);
    checkOutput("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("rst_fill", {28'd0, fill_level}, 32'd0);
    checkOutput("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
    checkOutput("rst_unf", {16'd0, underflow_cnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; iq_valid = 1'b0; rx2_en = 1'b0;
    stream_start = 1'b0; stream_stop = 1'b0; byte_req = 1'b0;
    {RX1_Q, RX1_I, RX2_Q, RX2_I} = '0;
    model_reset();
    tick(); tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();
    check_reset_outputs();

    $display("[TB] order, latency and underflow");
    applyStimulus({32'h11223344, 32'h55667788, $urandom, $urandom});
    check_levels("push1");
    start_stream();
    consume_frame(1'b0);
    consume_frame(1'b0);
    stop_stream();
    check_levels("order");

    $display("[TB] RX2 frame");
    rx2_en = 1'b1;
    applyStimulus({32'h11223344, 32'h55667788, 32'hA0A1A2A3, 32'hB0B1B2B3});
    start_stream();
    consume_frame(1'b1);
    stop_stream();
    check_levels("rx2");

    $display("[TB] overflow and push at full with pop");
    rx2_en = 1'b0;
    push_random(10);
    check_levels("overflow");
    start_stream();
    model_load(1'b0);
    drive_set({$urandom, $urandom, $urandom, $urandom});
    model_push({RX1_Q, RX1_I, RX2_Q, RX2_I});
    tick();
    iq_valid = 1'b0;
    check_levels("push_pop_full");
    read_bytes(exp_n);
    for (int i = 0; i < 8; i++) consume_frame(1'b0);
    stop_stream();
    check_levels("drain");

    $display("[TB] restart mid-frame");
    push_random(2);
    start_stream();
    model_load(1'b0);
    tick();
    read_bytes(3);
    stream_start = 1'b1;
    byte_req = 1'b1;
    tick();
    stream_start = 1'b0;
    byte_req = 1'b0;
    checkOutput("valid_restart", {31'd0, byte_valid}, 32'd0);
    consume_frame(1'b0);
    stop_stream();
    check_levels("restart");

    $display("[TB] stop keeps FIFO, stop beats start");
    rx2_en = 1'b1;
    push_random(2);
    start_stream();
    model_load(1'b1);
    tick();
    read_bytes(2);
    stream_stop = 1'b1;
    stream_start = 1'b1;
    tick();
    stream_stop = 1'b0;
    stream_start = 1'b0;
    checkOutput("valid_stop_pri", {31'd0, byte_valid}, 32'd0);
    check_levels("stop");
    byte_req = 1'b1;
    tick();
    byte_req = 1'b0;
    checkOutput("valid_idle_req", {31'd0, byte_valid}, 32'd0);
    start_stream();
    consume_frame(1'b1);
    stop_stream();
    check_levels("after_stop");

    $display("[TB] reset mid-frame");
    push_random(2);
    start_stream();
    model_load(1'b1);
    tick();
    read_bytes(1);
    reset = 1'b1;
    tick();
    check_reset_outputs();
    reset = 1'b0;
    model_reset();

    $display("[TB] sequence prefixes and underflow frame");
    rx2_en = 1'b0;
    push_random(3);
    start_stream();
    for (int i = 0; i < 4; i++) consume_frame(1'b0);
    stop_stream();
    check_levels("seq");

    $display("[TB] randomized rounds");
    for (int r = 0; r < 6; r++) begin
      push_random($urandom_range(0, 5));
      rx2_en = 1'($urandom_range(0, 1));
      start_stream();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) consume_frame(rx2_en);
      stop_stream();
      check_levels($sformatf("round%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_iq_stream_scheduler.md
Name: rx_iq_stream_scheduler

Overview:
- Single-clock scheduler between the receiver IQ datapath and the STM32 parallel-bus engine.
- Queues RX1/RX2 IQ samples in a small FIFO on each iq_valid strobe.
- Serves the samples to the bus engine as a byte stream on request, and tracks overflow and underflow.
- Sits between the DDC output stage and the bus command decoder's "RX IQ" transfer.

Parameters:
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 sample sets (default 8).
- SAMPLE_W, 32: width of each I/Q word. Must be a multiple of 8.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- iq_valid  input  1  one-cycle strobe, already synchronous to clk_in; new sample set present.
- RX1_I  input  SAMPLE_W  signed RX1 in-phase sample.
- RX1_Q  input  SAMPLE_W  signed RX1 quadrature sample.
- RX2_I  input  SAMPLE_W  signed RX2 in-phase sample.
- RX2_Q  input  SAMPLE_W  signed RX2 quadrature sample.
- rx2_en  input  1  include RX2 in frames; sampled at each frame load.
- stream_start  input  1  pulse; begin or restart the RX IQ byte stream.
- stream_stop  input  1  pulse; end the stream.
- byte_req  input  1  pulse; bus engine consumed byte_out and wants the next byte.
- byte_out  output  8  current stream byte.
- byte_valid  output  1  byte_out holds a meaningful byte.
- fill_level  output  DEPTH_LOG2+1  number of queued sample sets.
- overflow_cnt  output  16  dropped sample sets; saturates at 0xFFFF.
- underflow_cnt  output  16  frames served as zeros; saturates at 0xFFFF.

Behaviour:
- Reset values: byte_out=0, byte_valid=0, fill_level=0, both counters=0. FIFO pointers, hold registers and byte index cleared. State=IDLE. Reset mid-frame discards everything with no partial output.

Write side:
- On iq_valid with the FIFO not full: store {RX1_Q, RX1_I, RX2_Q, RX2_I} at wr_ptr; wr_ptr wraps modulo depth.
- On iq_valid with the FIFO full: drop the new set and increment overflow_cnt (saturating).
- Exception: when full, if a pop occurs in the same cycle, the push is accepted and overflow_cnt is not incremented.
- Push and pop in the same cycle leave fill_level unchanged.

Read-side FSM:
- IDLE: byte_valid=0. stream_start -> LOAD.
- LOAD (exactly 1 cycle): latch rx2_en into frame_rx2.
  - FIFO non-empty: pop into the hold registers.
  - FIFO empty: load zeros and increment underflow_cnt.
  - Set byte index to 0; -> SHIFT.
- SHIFT:
  - byte_valid=1; byte_out = byte[idx] of the frame, valid from the cycle after LOAD.
  - Frame order, MSB first within each word: RX1_Q, RX1_I, then RX2_Q, RX2_I if frame_rx2=1.
  - Frame length is 8 bytes (RX2 off) or 16 bytes (RX2 on), at the default SAMPLE_W.
  - byte_req: idx+1, and byte_out updates on the next edge (1-cycle latency).
  - byte_req on the last byte: -> LOAD. byte_valid is 0 for that one cycle; the stream is continuous.
- byte_req while byte_valid=0 is ignored.
- stream_stop in any state -> IDLE; the held frame is discarded, and FIFO contents are kept.
- stream_start while in SHIFT or LOAD -> LOAD; the held frame is discarded, not re-queued.
- Priority when both arrive: stream_stop over stream_start. Either one has priority over byte_req.
- Changes to rx2_en mid-frame take effect at the next LOAD only.

Optional Feature:
- Macro: RX_IQ_SEQNUM_EN.
- When defined:
  - Each FIFO entry also stores a 16-bit sequence number. It increments per accepted write, starts at 0 after reset, and wraps from 0xFFFF to 0.
  - Every frame is prefixed with seq[15:8], seq[7:0], giving 10 or 18 bytes per frame.
  - Underflow frames carry seq 0xFFFF.
- When undefined: no sequence storage, no prefix, frame lengths as in Behaviour.

Test Plan:
- Order and one-cycle latency: reset; push 1 set (RX1_Q=0x11223344, RX1_I=0x55667788); rx2_en=0; stream_start; pulse byte_req 8 times -> bytes 11 22 33 44 55 66 77 88, each following its byte_req by one cycle. Then LOAD with the FIFO empty -> all-zero frame, underflow_cnt=1.
- RX2 frame: rx2_en=1; push RX2_Q=0xA0A1A2A3, RX2_I=0xB0B1B2B3 with RX1 words as above -> 16 bytes; bytes 9-16 are A0..A3 B0..B3; fill_level returns to 0.
- Overflow: push 10 sets with no reads (depth 8) -> fill_level=8, overflow_cnt=2; the stream then delivers sets 1-8 in order.
- Simultaneous push and pop at full: FIFO full; iq_valid coincides with the LOAD pop -> push accepted, overflow_cnt unchanged, fill_level stays 8.
- Restart and stop: stream_start at byte 3 of a frame -> the next frame starts from a fresh pop and the old frame is lost. stream_stop -> byte_valid=0 on the next cycle, fill_level preserved. Also: reset asserted mid-frame -> all outputs back to their reset values on the next edge.
- With RX_IQ_SEQNUM_EN: push 3 sets; read -> prefixes 00 00, 00 01, 00 02; the next frame underflows -> prefix FF FF.
